// File: rtl/pc_unit_ras.sv
// Program-counter unit with stall, branch/jump selection, misaligned-target
// rejection and a circular return-address stack for call/return jumps.
module pc_unit_ras #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic [1:0]      pc_sel,
   input  logic [XLEN-1:0] imm,
   input  logic            branch_taken,
   input  logic            jump,
   input  logic            call,
   input  logic            ret,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_next,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            misalign
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
   localparam logic [XLEN-1:0]  FOUR     = XLEN'(4);

   typedef enum logic [1:0] {
      SEL_SEQ  = 2'b00,
      SEL_BR   = 2'b01,
      SEL_JMP  = 2'b10,
      SEL_SOFT = 2'b11
   } sel_e;

   logic [XLEN-1:0]  r_pc;
   logic             r_misalign;
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_count;
   logic [XLEN-1:0]  r_ras [RAS_DEPTH];

   sel_e             w_sel;
   logic [XLEN-1:0]  w_seq;
   logic [XLEN-1:0]  w_ras_top;
   logic [XLEN-1:0]  w_target;
   logic [PTR_W-1:0] w_top_idx;
   logic             w_eff_jump;
   logic             w_ret_hit;
   logic             w_bad;
   logic             w_push;
   logic             w_pop;

   assign w_sel      = sel_e'(pc_sel);
   assign w_seq      = r_pc + FOUR;
   assign w_top_idx  = r_ptr - PTR_W'(1);
   assign w_ras_top  = r_ras[w_top_idx];
   assign w_eff_jump = (w_sel == SEL_JMP) && jump && !stall;
   // A return with an empty stack falls back to imm and does not pop.
   assign w_ret_hit  = w_eff_jump && ret && !ras_empty;

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      w_target = w_seq;
      pc_next  = w_seq;
      case (w_sel)
         SEL_BR:  if (branch_taken) w_target = r_pc + imm;
         SEL_JMP: if (jump)         w_target = w_ret_hit ? w_ras_top : imm;
         default: ;
      endcase
      // The PC is always word aligned, so only branch/jump targets can trip this.
      w_bad = (w_sel != SEL_SOFT) && !stall && (w_target[1:0] != 2'b00);
      if (w_sel == SEL_SOFT)  pc_next = RESET_VEC;
      else if (stall || w_bad) pc_next = r_pc;
      else                     pc_next = w_target;
   end

   assign w_push = w_eff_jump && call && !w_bad;
   assign w_pop  = w_ret_hit && !w_bad;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst || (w_sel == SEL_SOFT)) begin
         r_pc       <= RESET_VEC;
         r_misalign <= 1'b0;
         r_ptr      <= '0;
         r_count    <= '0;
      end else if (stall) begin
         r_misalign <= 1'b0;
      end else begin
         r_pc       <= pc_next;
         r_misalign <= w_bad;
         if (w_push && !w_pop) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (r_count != FULL_CNT) r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // NOTE: stack storage is not reset; the count alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         // Call+return reuses the slot just popped; a plain call writes the free slot,
         // which is the oldest entry when the stack is full.
         if (w_pop) r_ras[w_top_idx] <= w_seq;
         else       r_ras[r_ptr]     <= w_seq;
      end
   end

   assign pc_out    = r_pc;
   assign misalign  = r_misalign;
   assign ras_empty = (r_count == '0);
   assign ras_full  = (r_count == FULL_CNT);

endmodule

// File: tb/tb_pc_unit_ras.sv
// Randomised bench for pc_unit_ras: a queue-based stack model predicts each
// cycle, a negedge monitor compares DUT outputs against the scoreboard.
module tb_pc_unit_ras;

   localparam int          XLEN  = 32;
   localparam logic [31:0] RVEC  = 32'h0;
   localparam int          DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst, stall, branch_taken, jump, call, ret;
   logic [1:0]      pc_sel;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] pc_out, pc_next;
   logic            ras_empty, ras_full, misalign;

   pc_unit_ras #(.XLEN(XLEN), .RESET_VEC(RVEC), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .imm(imm),
      .branch_taken(branch_taken), .jump(jump), .call(call), .ret(ret),
      .pc_out(pc_out), .pc_next(pc_next), .ras_empty(ras_empty),
      .ras_full(ras_full), .misalign(misalign)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] nx;
      logic        mis;
      logic        emp;
      logic        full;
      logic        known;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] ras_q[$];
   logic [31:0] m_pc    = '0;
   logic        m_mis   = 1'b0;
   logic        m_known = 1'b0;
   int          total   = 0;
   int          bad     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per cycle, sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.known) begin
               check("pc_out",    pc_out,           e.pc);
               check("pc_next",   pc_next,          e.nx);
               check("misalign",  {31'b0, misalign}, {31'b0, e.mis});
               check("ras_empty", {31'b0, ras_empty}, {31'b0, e.emp});
               check("ras_full",  {31'b0, ras_full},  {31'b0, e.full});
            end
         end
      end
   end

   // One clock of stimulus: predict, enqueue, wait for the edge, advance the model.
   task automatic cyc(input logic r, input logic s, input logic [1:0] sel,
                      input logic [31:0] im, input logic tk, input logic j,
                      input logic c, input logic rt);
      exp_t        e;
      logic [31:0] nx, tgt;
      logic        bd;
      rst = r; stall = s; pc_sel = sel; imm = im;
      branch_taken = tk; jump = j; call = c; ret = rt;
      bd = 1'b0;
      if (sel == 2'b11) nx = RVEC;
      else if (s)       nx = m_pc;
      else begin
         if (sel == 2'b01)      tgt = tk ? m_pc + im : m_pc + 32'd4;
         else if (sel == 2'b10) tgt = !j ? m_pc + 32'd4 : ((rt && ras_q.size() > 0) ? ras_q[$] : im);
         else                   tgt = m_pc + 32'd4;
         if (tgt[1:0] != 2'b00) begin bd = 1'b1; nx = m_pc; end
         else nx = tgt;
      end
      e.pc    = m_pc;
      e.nx    = nx;
      e.mis   = m_mis;
      e.emp   = (ras_q.size() == 0);
      e.full  = (ras_q.size() == DEPTH);
      e.known = m_known;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (r || sel == 2'b11) begin
         m_pc = RVEC; m_mis = 1'b0; ras_q.delete(); m_known = 1'b1;
      end else if (s) begin
         m_mis = 1'b0;
      end else begin
         if (!bd && sel == 2'b10 && j) begin
            if (rt && ras_q.size() > 0) void'(ras_q.pop_back());
            if (c) begin
               ras_q.push_back(m_pc + 32'd4);
               if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end
         end
         m_pc  = nx;
         m_mis = bd;
      end
   endtask

   task automatic jmp(input logic [31:0] a);
      cyc(0, 0, 2'b10, a, 0, 1, 0, 0);
   endtask

   initial begin
      int          w;
      logic [1:0]  sel;
      logic [31:0] im;
      rst = 1; stall = 0; pc_sel = 0; imm = 0;
      branch_taken = 0; jump = 0; call = 0; ret = 0;
      @(posedge clk);
      #1;
      // Reset then free-run
      cyc(1, 0, 2'b00, 0, 0, 0, 0, 0);
      cyc(1, 0, 2'b00, 0, 0, 0, 0, 0);
      repeat (4) cyc(0, 0, 2'b00, 0, 0, 0, 0, 0);
      // Branches, including a misaligned target
      jmp(32'h10);
      cyc(0, 0, 2'b01, 32'hFFFF_FFF8, 1, 0, 0, 0);
      cyc(0, 0, 2'b01, 32'hFFFF_FFF8, 0, 0, 0, 0);
      jmp(32'h10);
      cyc(0, 0, 2'b01, 32'h6, 1, 0, 0, 0);
      cyc(0, 0, 2'b00, 0, 0, 0, 0, 0);
      // Call and return
      jmp(32'h20);
      cyc(0, 0, 2'b10, 32'h100, 0, 1, 1, 0);
      cyc(0, 0, 2'b10, 32'h0,   0, 1, 0, 1);
      // Overflow: five calls then five returns
      cyc(0, 0, 2'b11, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) cyc(0, 0, 2'b10, 32'(i) << 8, 0, 1, 1, 0);
      for (int i = 0; i < 5; i++)  cyc(0, 0, 2'b10, 32'h800, 0, 1, 0, 1);
      // Stall, then soft reset overriding stall
      jmp(32'h40);
      cyc(0, 0, 2'b10, 32'h80, 0, 1, 1, 0);
      repeat (3) cyc(0, 1, 2'b01, 32'h8, 1, 0, 0, 0);
      cyc(0, 1, 2'b11, 0, 0, 0, 0, 0);
      cyc(0, 0, 2'b00, 0, 0, 0, 0, 0);
      // Wrap-around and reset colliding with a call
      jmp(32'hFFFF_FFFC);
      cyc(0, 0, 2'b00, 0, 0, 0, 0, 0);
      cyc(1, 0, 2'b10, 32'h200, 0, 1, 1, 0);
      cyc(0, 0, 2'b00, 0, 0, 0, 0, 0);
      // Random traffic
      for (int n = 0; n < 600; n++) begin
         w = $urandom_range(0, 15);
         sel = (w < 5) ? 2'b00 : (w < 9) ? 2'b01 : (w < 15) ? 2'b10 : 2'b11;
         im  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 4095))
                                           : 32'($urandom_range(0, 1023)) << 2;
         if (sel == 2'b01 && $urandom_range(0, 1) == 1) im = -im;
         cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 12, sel, im,
             1'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0);
      end
      for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
